// File: rtl/sci_rx_framer_pkg.sv
// Shared definitions for the SCI receive framer: FSM state encodings, default sync byte,
// status pulse bit positions and the LEN range helper.
package sci_rx_framer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEN   = 3'd1,
      ST_DATA  = 3'd2,
      ST_CHK   = 3'd3,
      ST_DRAIN = 3'd4
   } state_t;

   localparam logic [7:0] SYNC_DEFAULT = 8'hAA;

   localparam int STAT_OK_BIT  = 0;
   localparam int STAT_ERR_BIT = 1;
   localparam int STAT_OVR_BIT = 2;
   localparam int STAT_W       = 3;

   // A LEN byte is usable only if it is non-zero and fits the payload buffer.
   function automatic logic len_ok(input logic [7:0] len, input int max_len);
      return (len != 8'd0) && (int'(len) <= max_len);
   endfunction

endpackage

// File: rtl/sci_byte_strobe.sv
// Qualifies SCI receiver completions: rx_ready rising edge after a long enough busy period
// becomes byte_stb; rx_error rising edge becomes err_stb.
module sci_byte_strobe #(
   parameter int MIN_BUSY = 32
) (
   input  logic       baud_clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_ready,
   input  logic       rx_error,
   output logic       byte_stb,
   output logic [7:0] rx_byte,
   output logic       err_stb
);

   localparam int             CW       = $clog2(MIN_BUSY + 1);
   localparam logic [CW-1:0]  BUSY_SAT = CW'(MIN_BUSY);

   logic          rdy_prev_reg;
   logic          err_prev_reg;
   logic [CW-1:0] busy_cnt_reg;
   logic [CW-1:0] busy_cnt_next;
   logic          rdy_rise;

   assign rdy_rise = rx_ready & ~rdy_prev_reg;

   // Saturating at MIN_BUSY is enough: only ">= MIN_BUSY" is ever asked.
   always_comb begin
      busy_cnt_next = busy_cnt_reg;
      if (rdy_rise)
         busy_cnt_next = '0;
      else if (!rx_ready && (busy_cnt_reg != BUSY_SAT))
         busy_cnt_next = busy_cnt_reg + CW'(1);
   end

   // The line idles with rx_ready high, so the previous value starts high.
   always_ff @(posedge baud_clk or posedge rst) begin
      if (rst) begin
         rdy_prev_reg <= 1'b1;
         err_prev_reg <= 1'b0;
         busy_cnt_reg <= '0;
      end else begin
         rdy_prev_reg <= rx_ready;
         err_prev_reg <= rx_error;
         busy_cnt_reg <= busy_cnt_next;
      end
   end

   assign byte_stb = rdy_rise && (busy_cnt_reg >= BUSY_SAT) && !rx_error;
   assign err_stb  = rx_error & ~err_prev_reg;
   assign rx_byte  = rx_data;

endmodule

// File: rtl/sci_rx_framer.sv
// Frame parser [SYNC][LEN][payload][SUM] that buffers the payload and streams it out only
// when the checksum matches. Optional inter-byte timeout: define SCI_FRAME_TIMEOUT_EN.
module sci_rx_framer
   import sci_rx_framer_pkg::*;
#(
   parameter int         MAX_LEN  = 16,
   parameter logic [7:0] SYNC     = SYNC_DEFAULT,
   parameter int         MIN_BUSY = 32,
   parameter int         TIMEOUT  = 255
) (
   input  logic       baud_clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_ready,
   input  logic       rx_error,
   output logic [7:0] out_data,
   output logic       out_valid,
   output logic       out_last,
   input  logic       out_ready,
   output logic       frame_ok,
   output logic       frame_err,
   output logic       overrun
);

   localparam int IW = $clog2(MAX_LEN);

   state_t              state_reg, state_next;
   logic [IW-1:0]       len_m1_reg, len_m1_next;
   logic [IW-1:0]       idx_reg, idx_next;
   logic [IW-1:0]       rd_reg, rd_next;
   logic [7:0]          sum_reg, sum_next;
   logic [STAT_W-1:0]   status_reg, status_next;
   logic                buf_we;
   logic [7:0]          buf_mem [MAX_LEN];

   logic                byte_stb;
   logic                err_stb;
   logic [7:0]          rx_byte;
   logic                timeout_hit;

   sci_byte_strobe #(
      .MIN_BUSY (MIN_BUSY)
   ) u_strobe (
      .baud_clk (baud_clk),
      .rst      (rst),
      .rx_data  (rx_data),
      .rx_ready (rx_ready),
      .rx_error (rx_error),
      .byte_stb (byte_stb),
      .rx_byte  (rx_byte),
      .err_stb  (err_stb)
   );

`ifdef SCI_FRAME_TIMEOUT_EN
   localparam int            GW      = $clog2(TIMEOUT + 1);
   localparam logic [GW-1:0] GAP_MAX = GW'(TIMEOUT);

   logic [GW-1:0] gap_cnt_reg;
   logic          in_frame;

   assign in_frame = (state_reg == ST_LEN) || (state_reg == ST_DATA) || (state_reg == ST_CHK);

   always_ff @(posedge baud_clk or posedge rst) begin
      if (rst)
         gap_cnt_reg <= '0;
      else if (!in_frame || byte_stb)
         gap_cnt_reg <= '0;
      else if (gap_cnt_reg != GAP_MAX)
         gap_cnt_reg <= gap_cnt_reg + GW'(1);
   end

   assign timeout_hit = in_frame && (gap_cnt_reg == GAP_MAX);
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
   assign timeout_hit    = 1'b0;
`endif

   always_comb begin
      state_next  = state_reg;
      len_m1_next = len_m1_reg;
      idx_next    = idx_reg;
      rd_next     = rd_reg;
      sum_next    = sum_reg;
      status_next = '0;
      buf_we      = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (byte_stb && !err_stb && (rx_byte == SYNC))
               state_next = ST_LEN;
         end
         ST_LEN, ST_DATA, ST_CHK: begin
            // An error event outranks a byte completing in the same cycle.
            if (err_stb || timeout_hit) begin
               status_next[STAT_ERR_BIT] = 1'b1;
               state_next                = ST_IDLE;
            end else if (byte_stb) begin
               case (state_reg)
                  ST_LEN: begin
                     if (len_ok(rx_byte, MAX_LEN)) begin
                        len_m1_next = IW'(rx_byte - 8'd1);
                        sum_next    = rx_byte;
                        idx_next    = '0;
                        state_next  = ST_DATA;
                     end else begin
                        status_next[STAT_ERR_BIT] = 1'b1;
                        state_next                = ST_IDLE;
                     end
                  end
                  ST_DATA: begin
                     buf_we   = 1'b1;
                     sum_next = sum_reg + rx_byte;
                     idx_next = idx_reg + IW'(1);
                     if (idx_reg == len_m1_reg)
                        state_next = ST_CHK;
                  end
                  default: begin
                     if (rx_byte == sum_reg) begin
                        status_next[STAT_OK_BIT] = 1'b1;
                        rd_next                  = '0;
                        state_next               = ST_DRAIN;
                     end else begin
                        status_next[STAT_ERR_BIT] = 1'b1;
                        state_next                = ST_IDLE;
                     end
                  end
               endcase
            end
         end
         ST_DRAIN: begin
            // The buffer is still being read out, so a new byte has nowhere to go.
            if (byte_stb)
               status_next[STAT_OVR_BIT] = 1'b1;
            if (out_ready) begin
               if (rd_reg == len_m1_reg)
                  state_next = ST_IDLE;
               else
                  rd_next = rd_reg + IW'(1);
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge baud_clk or posedge rst) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         len_m1_reg <= '0;
         idx_reg    <= '0;
         rd_reg     <= '0;
         sum_reg    <= '0;
         status_reg <= '0;
      end else begin
         state_reg  <= state_next;
         len_m1_reg <= len_m1_next;
         idx_reg    <= idx_next;
         rd_reg     <= rd_next;
         sum_reg    <= sum_next;
         status_reg <= status_next;
      end
   end

   // Buffer contents are don't-care after reset, so no reset on the array.
   always_ff @(posedge baud_clk) begin
      if (buf_we)
         buf_mem[idx_reg] <= rx_byte;
   end

   assign out_valid = (state_reg == ST_DRAIN);
   assign out_data  = out_valid ? buf_mem[rd_reg] : 8'h00;
   assign out_last  = out_valid && (rd_reg == len_m1_reg);
   assign frame_ok  = status_reg[STAT_OK_BIT];
   assign frame_err = status_reg[STAT_ERR_BIT];
   assign overrun   = status_reg[STAT_OVR_BIT];

endmodule

// File: tb/tb_sci_rx_framer.sv
// Scoreboard bench for sci_rx_framer: stimulus queues expected payload bytes, a negedge
// monitor pops and compares on every handshake and tallies status pulses.
module tb_sci_rx_framer;

   localparam int MAX_LEN  = 16;
   localparam int MIN_BUSY = 32;
   localparam int TIMEOUT  = 50;

   logic       baud_clk  = 1'b0;
   logic       rst       = 1'b1;
   logic [7:0] rx_data   = 8'h00;
   logic       rx_ready  = 1'b1;
   logic       rx_error  = 1'b0;
   logic       out_ready = 1'b1;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_last;
   logic       frame_ok;
   logic       frame_err;
   logic       overrun;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;
   int ok_cnt  = 0;
   int err_cnt = 0;
   int ovr_cnt = 0;
   int vld_cnt = 0;

   logic [8:0] exp_q[$];
   int         hs_cyc[$];

   logic       prev_stall = 1'b0;
   logic [7:0] prev_data  = 8'h00;
   logic       prev_last  = 1'b0;
   logic [8:0] mon_e;

   sci_rx_framer #(
      .MAX_LEN  (MAX_LEN),
      .SYNC     (8'hAA),
      .MIN_BUSY (MIN_BUSY),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .baud_clk  (baud_clk),
      .rst       (rst),
      .rx_data   (rx_data),
      .rx_ready  (rx_ready),
      .rx_error  (rx_error),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_ready (out_ready),
      .frame_ok  (frame_ok),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 baud_clk = ~baud_clk;

   always @(posedge baud_clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Monitor: pulse tallies, hold-stability, and scoreboard pop on each handshake.
   always @(negedge baud_clk) begin
      if (frame_ok) begin
         ok_cnt++;
         check("ok_with_valid", int'(out_valid), 1);
      end
      if (frame_err) err_cnt++;
      if (overrun)   ovr_cnt++;
      if (out_valid) vld_cnt++;
      if (prev_stall && out_valid && !rst) begin
         check("hold_data", int'(out_data), int'(prev_data));
         check("hold_last", int'(out_last), int'(prev_last));
      end
      if (out_valid && out_ready) begin
         hs_cyc.push_back(cyc);
         $display("[%0d] out %02h last %0b", cyc, out_data, out_last);
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_out: got %02h, expected no output", out_data);
         end else begin
            mon_e = exp_q.pop_front();
            check("out_data", int'(out_data), int'(mon_e[7:0]));
            check("out_last", int'(out_last), int'(mon_e[8]));
         end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
   end

   task automatic step(input int n);
      repeat (n) @(posedge baud_clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      step(1);
      rx_ready = 1'b0;
      step(MIN_BUSY + 2);
      rx_data  = b;
      rx_ready = 1'b1;
      step(2);
   endtask

   task automatic false_start();
      rx_ready = 1'b0;
      step(4);
      rx_ready = 1'b1;
      step(3);
   endtask

   task automatic err_pulse();
      rx_error = 1'b1;
      step(2);
      rx_error = 1'b0;
      step(2);
   endtask

   // Bytes packed MSB-first: the first byte sent is the most significant of the n used.
   task automatic send_frame(input logic [63:0] v, input int n);
      $display("[%0d] frame of %0d bytes sent", cyc, n);
      for (int i = 0; i < n; i++) send_byte(v[8*(n-1-i) +: 8]);
   endtask

   task automatic expect_payload(input logic [63:0] v, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), v[8*(n-1-i) +: 8]});
   endtask

   task automatic wait_drained(input string name);
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) step(1);
      check(name, exp_q.size(), 0);
      step(3);
   endtask

   task automatic wait_valid(input string name);
      for (int i = 0; i < 300 && !out_valid; i++) step(1);
      check(name, int'(out_valid), 1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int o0, e0, v0, r0;

      step(3);
      check("rst_valid", int'(out_valid), 0);
      check("rst_data",  int'(out_data),  0);
      check("rst_status", int'({frame_ok, frame_err, overrun, out_last}), 0);
      rst = 1'b0;
      step(3);

      // 1: good frame, streamed back-to-back
      o0 = ok_cnt; e0 = err_cnt; hs_cyc.delete();
      expect_payload(64'({8'h11, 8'h22, 8'h33}), 3);
      send_frame(64'({8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}), 6);
      wait_drained("t1_drained");
      check("t1_ok", ok_cnt - o0, 1);
      check("t1_err", err_cnt - e0, 0);
      check("t1_hs_count", hs_cyc.size(), 3);
      if (hs_cyc.size() == 3) check("t1_consecutive", hs_cyc[2] - hs_cyc[0], 2);

      // 2: bad checksum
      o0 = ok_cnt; e0 = err_cnt; v0 = vld_cnt;
      send_frame(64'({8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h76}), 6);
      step(10);
      check("t2_err", err_cnt - e0, 1);
      check("t2_ok", ok_cnt - o0, 0);
      check("t2_no_valid", vld_cnt - v0, 0);

      // 3: LEN out of range, then recovery
      e0 = err_cnt;
      send_frame(64'({8'hAA, 8'h00}), 2);
      check("t3_len0_err", err_cnt - e0, 1);
      send_frame(64'({8'hAA, 8'h11}), 2);
      check("t3_len17_err", err_cnt - e0, 2);
      o0 = ok_cnt;
      expect_payload(64'({8'h5A}), 1);
      send_frame(64'({8'hAA, 8'h01, 8'h5A, 8'h5B}), 4);
      wait_drained("t3_drained");
      check("t3_ok", ok_cnt - o0, 1);

      // 4a: false start mid-DATA is ignored
      o0 = ok_cnt; e0 = err_cnt;
      expect_payload(64'({8'h11, 8'h22, 8'h33}), 3);
      send_frame(64'({8'hAA, 8'h03, 8'h11}), 3);
      false_start();
      send_frame(64'({8'h22, 8'h33, 8'h69}), 3);
      wait_drained("t4_drained");
      check("t4_ok", ok_cnt - o0, 1);
      check("t4_err", err_cnt - e0, 0);

      // 4b: rx_error mid-DATA aborts the frame
      o0 = ok_cnt; e0 = err_cnt; v0 = vld_cnt;
      send_frame(64'({8'hAA, 8'h03, 8'h11}), 3);
      err_pulse();
      check("t4_rxerr_err", err_cnt - e0, 1);
      send_frame(64'({8'h22, 8'h33, 8'h69}), 3);
      step(5);
      check("t4_rxerr_ok", ok_cnt - o0, 0);
      check("t4_rxerr_valid", vld_cnt - v0, 0);

      // 5: stalled drain plus a new SYNC byte -> overrun, data held
      out_ready = 1'b0;
      r0 = ovr_cnt;
      expect_payload(64'({8'h05, 8'h06}), 2);
      send_frame(64'({8'hAA, 8'h02, 8'h05, 8'h06, 8'h0D}), 5);
      wait_valid("t5_valid");
      send_byte(8'hAA);
      check("t5_overrun", ovr_cnt - r0, 1);
      check("t5_held", int'(out_data), 8'h05);
      step(5);
      out_ready = 1'b1;
      wait_drained("t5_drained");

      // 6: 60-cycle gap after LEN
      o0 = ok_cnt; e0 = err_cnt;
`ifdef SCI_FRAME_TIMEOUT_EN
      send_frame(64'({8'hAA, 8'h02}), 2);
      step(60);
      check("t6_timeout_err", err_cnt - e0, 1);
      send_frame(64'({8'h01, 8'h02, 8'h05}), 3);
      step(5);
      check("t6_timeout_ok", ok_cnt - o0, 0);
`else
      expect_payload(64'({8'h01, 8'h02}), 2);
      send_frame(64'({8'hAA, 8'h02}), 2);
      step(60);
      send_frame(64'({8'h01, 8'h02, 8'h05}), 3);
      wait_drained("t6_drained");
      check("t6_ok", ok_cnt - o0, 1);
      check("t6_err", err_cnt - e0, 0);
`endif

      // rst mid-DRAIN clears outputs without waiting for a clock
      out_ready = 1'b0;
      expect_payload(64'({8'h99}), 1);
      send_frame(64'({8'hAA, 8'h01, 8'h99, 8'h9A}), 4);
      wait_valid("rst_drain_valid");
      check("rst_drain_data_pre", int'(out_data), 8'h99);
      @(posedge baud_clk);
      #3;
      rst = 1'b1;
      #1;
      check("rst_async_valid", int'(out_valid), 0);
      check("rst_async_data",  int'(out_data),  0);
      check("rst_async_last",  int'(out_last),  0);
      exp_q.delete();
      step(2);
      rst = 1'b0;
      out_ready = 1'b1;
      step(3);

      o0 = ok_cnt;
      expect_payload(64'({8'h42}), 1);
      send_frame(64'({8'hAA, 8'h01, 8'h42, 8'h43}), 4);
      wait_drained("post_rst_drained");
      check("post_rst_ok", ok_cnt - o0, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
